load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Pipeline-side initiator for data_mem: takes one load/store request per handshake, builds the DMEM
//  re/raddr/we/waddr/wdata/wstrb cycle from RV32 funct3 and address, and returns load data aligned and
//  sign/zero-extended. Sits in the MEM stage between the execute result and data_mem (1-cycle sync read).
// PARAMETERS
//  AW  32  byte-address width (DMEM word index = addr[AW-1:2])
//  DW  32  data width; fixed at 32 (byte lanes = 4)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted when valid&&ready
//  req_is_store in   1   1=store, 0=load
//  req_funct3   in   3   RV32 width/sign code
//  req_addr     in   AW  byte address
//  req_wdata    in   32  store data (LSB-justified)
//  req_rd       in   5   destination tag, echoed on response
//  rsp_valid    out  1   one-cycle response pulse
//  rsp_data     out  32  extended load data (0 for stores/errors)
//  rsp_rd       out  5   echoed tag
//  rsp_err      out  1   access faulted; no memory write took place
//  rsp_cause    out  2   01 misaligned, 10 illegal funct3, 00 none
//  dmem_re/dmem_raddr  out 1/AW   to data_mem re/raddr (word-aligned, [1:0]=0)
//  dmem_we/dmem_waddr  out 1/AW   to data_mem we/waddr (word-aligned)
//  dmem_wdata/dmem_wstrb out 32/4 lane-shifted data, byte strobes
//  dmem_rdata   in   32  data_mem rdata, valid 1 cycle after re
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1 after release; rsp_*=0; dmem_re/we=0; all strobes 0. Reset mid-access
//    aborts it; no response is issued for the aborted request.
//  - funct3: load 000 LB,001 LH,010 LW,100 LBU,101 LHU; store 000 SB,001 SH,010 SW. Others -> illegal.
//  - req_ready = (state==IDLE). DMEM ports are driven combinationally from req_* in the accept cycle T.
//  - Store, aligned: T: we=1, wstrb = lane mask << addr[1:0] (SB 0001,SH 0011,SW 1111), wdata = data<<(8*addr[1:0]).
//    T+1: rsp_valid=1, rsp_data=0; state stays IDLE (one store per cycle).
//  - Load, aligned: T: re=1; state->LOAD_LAST. T+1: rsp_valid=1, rsp_data=extract(dmem_rdata); ready=0.
//    T+2: IDLE. Throughput one load per 2 cycles.
//  - Extract: byte/half picked by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
//  - Misaligned = half with addr[0]=1, word with addr[1:0]!=0. Illegal beats misaligned in cause priority.
//  - Error: no re/we in T; T+1 rsp_valid=1, rsp_err=1, rsp_cause set, rsp_data=0.
//  - States: IDLE, LOAD_LAST, LOAD_HI, STORE_HI (last two only with split feature).
//  - Never assert re and we in the same cycle.
// CONFIGURATION
//  MISALIGNED_SPLIT_EN undefined: misaligned -> error response as above.
//  MISALIGNED_SPLIT_EN defined: misaligned access split into beats at A=addr&~3 and A+4 (mod 2^AW,
//   0xFFFFFFFC wraps to 0x0). Load: T re@A ->LOAD_HI; T+1 latch low bytes, re@A+4 ->LOAD_LAST;
//   T+2 merge+extend, rsp_valid. Store: T we@A upper-lane strobes; ->STORE_HI; T+1 we@A+4 remaining
//   strobes; T+2 rsp_valid, IDLE. req_ready=0 throughout. Never sets cause 01.
// STRUCTURE
//  lsu_pkg: funct3 constants, state encoding, cause codes, lane-mask function.
//  Sub-module lsu_load_align: combinational byte select/merge + sign/zero extension.
// TESTING
//  1 SW 0xDEADBEEF @0x10, then LW @0x10 -> wstrb 1111; load rsp at accept+1 = 0xDEADBEEF, rsp_rd echoed.
//  2 SB 0x80 @0x13; LB @0x13 -> wstrb 1000, wdata 0x80000000; rsp_data 0xFFFFFF80; LBU -> 0x00000080.
//  3 LH @0x11, split off -> rsp_err=1, cause 01, no re/we; funct3=011 -> cause 10, no memory write.
//  4 split on: SW 0x11223344 @0x0E -> beats @0x0C strb 1100, @0x10 strb 0011; LW @0x0E -> 0x11223344 at T+2.
//  5 back-to-back SW every cycle x4 -> req_ready stays 1, 4 rsp pulses; LW blocks ready exactly 1 cycle.
//  6 rst_n low during LOAD_HI -> outputs 0 immediately, no rsp_valid; first request after release works.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store unit shared constants, state/cause encodings and lane-mask helper
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD_LAST = 2'd1,
        ST_LOAD_HI   = 2'd2,
        ST_STORE_HI  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE       = 2'b00,
        CAUSE_MISALIGNED = 2'b01,
        CAUSE_ILLEGAL    = 2'b10
    } lsu_cause_e;

    // funct3[1:0] encodes access size: 0 byte, 1 half, 2 word
    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        case (size)
            2'd0:    lane_mask = 4'b0001;
            2'd1:    lane_mask = 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            funct3_legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                           (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - combinational load byte select/merge with sign/zero extension
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [63:0] merged;
    logic [31:0] shifted;

    // hi_word is zero for single-beat loads, so one shifter covers both cases
    always_comb begin
        merged  = {hi_word, lo_word} >> {offset, 3'b000};
        shifted = merged[31:0];
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for data_mem; MISALIGNED_SPLIT_EN enables two-beat misaligned accesses
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_is_store,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [4:0]    req_rd,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic [4:0]    rsp_rd,
    output logic          rsp_err,
    output logic [1:0]    rsp_cause,
    output logic          dmem_re,
    output logic [AW-1:0] dmem_raddr,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_waddr,
    output logic [DW-1:0] dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic [DW-1:0] dmem_rdata
);

    lsu_state_e    state, state_d;
    logic          accept;
    logic [1:0]    size, off;
    logic          illegal, misaligned, err, do_split;
    lsu_cause_e    cause;
    logic [AW-1:0] addr_lo;
    logic [3:0]    store_strb;
    logic [DW-1:0] store_data;

    logic          rsp_q_valid, rsp_q_err;
    lsu_cause_e    rsp_q_cause;
    logic [4:0]    rd_q;
    logic [2:0]    f3_q;
    logic [1:0]    off_q;
    logic [DW-1:0] load_data, align_lo, align_hi;

    assign accept     = req_valid && (state == ST_IDLE);
    assign req_ready  = (state == ST_IDLE);
    assign size       = req_funct3[1:0];
    assign off        = req_addr[1:0];
    assign addr_lo    = {req_addr[AW-1:2], 2'b00};
    assign illegal    = !funct3_legal(req_is_store, req_funct3);
    assign misaligned = ((size == 2'd1) && off[0]) || ((size == 2'd2) && (off != 2'd0));
    // illegal funct3 takes priority over misalignment
    assign cause      = illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGNED;

`ifdef MISALIGNED_SPLIT_EN
    logic [7:0]    strb_wide;
    logic [63:0]   data_wide;
    logic [AW-1:0] addr_hi_q;
    logic [3:0]    strb_hi_q;
    logic [DW-1:0] data_hi_q, lo_q;
    logic          split_q;

    assign strb_wide  = {4'b0000, lane_mask(size)} << off;
    assign data_wide  = {32'h0, req_wdata} << {off, 3'b000};
    assign store_strb = strb_wide[3:0];
    assign store_data = data_wide[31:0];
    assign do_split   = !illegal && misaligned;
    assign err        = illegal;
    assign align_lo   = split_q ? lo_q : dmem_rdata;
    assign align_hi   = split_q ? dmem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hi_q <= '0;
            strb_hi_q <= '0;
            data_hi_q <= '0;
            lo_q      <= '0;
            split_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_hi_q <= addr_lo + AW'(4);
                strb_hi_q <= strb_wide[7:4];
                data_hi_q <= data_wide[63:32];
                split_q   <= do_split;
            end
            if (state == ST_LOAD_HI)
                lo_q <= dmem_rdata;
        end
    end
`else
    assign store_strb = lane_mask(size) << off;
    assign store_data = req_wdata << {off, 3'b000};
    assign do_split   = 1'b0;
    assign err        = illegal || misaligned;
    assign align_lo   = dmem_rdata;
    assign align_hi   = '0;
`endif

    always_comb begin
        state_d    = state;
        dmem_re    = 1'b0;
        dmem_raddr = '0;
        dmem_we    = 1'b0;
        dmem_waddr = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        case (state)
            ST_IDLE: begin
                if (accept && !err) begin
                    if (req_is_store) begin
                        dmem_we    = 1'b1;
                        dmem_waddr = addr_lo;
                        dmem_wstrb = store_strb;
                        dmem_wdata = store_data;
                        if (do_split)
                            state_d = ST_STORE_HI;
                    end else begin
                        dmem_re    = 1'b1;
                        dmem_raddr = addr_lo;
                        state_d    = do_split ? ST_LOAD_HI : ST_LOAD_LAST;
                    end
                end
            end
            ST_LOAD_LAST: state_d = ST_IDLE;
`ifdef MISALIGNED_SPLIT_EN
            ST_LOAD_HI: begin
                dmem_re    = 1'b1;
                dmem_raddr = addr_hi_q;
                state_d    = ST_LOAD_LAST;
            end
            ST_STORE_HI: begin
                dmem_we    = 1'b1;
                dmem_waddr = addr_hi_q;
                dmem_wstrb = strb_hi_q;
                dmem_wdata = data_hi_q;
                state_d    = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rsp_q_valid <= 1'b0;
            rsp_q_err   <= 1'b0;
            rsp_q_cause <= CAUSE_NONE;
            rd_q        <= '0;
            f3_q        <= '0;
            off_q       <= '0;
        end else begin
            state       <= state_d;
            // stores and errors answer from registers; loads answer combinationally in LOAD_LAST
            rsp_q_valid <= (accept && (err || (req_is_store && !do_split))) ||
                           (state == ST_STORE_HI);
            rsp_q_err   <= accept && err;
            rsp_q_cause <= (accept && err) ? cause : CAUSE_NONE;
            if (accept) begin
                rd_q  <= req_rd;
                f3_q  <= req_funct3;
                off_q <= off;
            end
        end
    end

    lsu_load_align u_align (
        .lo_word (align_lo),
        .hi_word (align_hi),
        .offset  (off_q),
        .funct3  (f3_q),
        .data    (load_data)
    );

    assign rsp_valid = rsp_q_valid || (state == ST_LOAD_LAST);
    assign rsp_data  = (state == ST_LOAD_LAST) ? load_data : '0;
    assign rsp_rd    = rsp_valid ? rd_q : '0;
    assign rsp_err   = rsp_q_err;
    assign rsp_cause = rsp_q_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a data_mem model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic [1:0]  rsp_cause;
    logic        dmem_re, dmem_we;
    logic [31:0] dmem_raddr, dmem_waddr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    logic [31:0] mem [0:63];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .rsp_err(rsp_err), .rsp_cause(rsp_cause),
        .dmem_re(dmem_re), .dmem_raddr(dmem_raddr), .dmem_we(dmem_we), .dmem_waddr(dmem_waddr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata)
    );

    always @(posedge clk) begin
        if (dmem_we)
            for (int b = 0; b < 4; b++)
                if (dmem_wstrb[b]) mem[dmem_waddr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
        if (dmem_re)
            dmem_rdata <= mem[dmem_raddr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        #1;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd, input logic [3:0] strb, input logic [31:0] lane_data);
        drive(1'b1, f3, a, wd, rd);
        check("st_we", 32'(dmem_we), 32'd1);
        check("st_waddr", dmem_waddr, {a[31:2], 2'b00});
        check("st_wstrb", 32'(dmem_wstrb), 32'(strb));
        check("st_wdata", dmem_wdata, lane_data);
        tick(); idle();
        check("st_rsp_valid", 32'(rsp_valid), 32'd1);
        check("st_rsp_data", rsp_data, 32'h0);
        check("st_rsp_rd", 32'(rsp_rd), 32'(rd));
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] exp);
        drive(1'b0, f3, a, 32'h0, rd);
        check("ld_re", 32'(dmem_re), 32'd1);
        check("ld_we", 32'(dmem_we), 32'd0);
        tick(); idle();
        check("ld_rsp_valid", 32'(rsp_valid), 32'd1);
        check("ld_rsp_data", rsp_data, exp);
        check("ld_rsp_rd", 32'(rsp_rd), 32'(rd));
        check("ld_ready_low", 32'(req_ready), 32'd0);
        tick();
    endtask

    task automatic do_err(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] exp_cause);
        drive(st, f3, a, wd, 5'd3);
        check("err_no_access", 32'({dmem_re, dmem_we}), 32'd0);
        tick(); idle();
        check("err_rsp_valid", 32'(rsp_valid), 32'd1);
        check("err_rsp_err", 32'(rsp_err), 32'd1);
        check("err_cause", 32'(rsp_cause), 32'(exp_cause));
        check("err_rsp_data", rsp_data, 32'h0);
    endtask

    initial begin
        logic [31:0] rst_addr;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        dmem_rdata = '0;
        rst_n = 1'b0;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_dmem", 32'({dmem_re, dmem_we, dmem_wstrb}), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(req_ready), 32'd1);

        // SW then LW round trip
        do_store(3'b010, 32'h10, 32'hDEADBEEF, 5'd5, 4'b1111, 32'hDEADBEEF);
        do_load(3'b010, 32'h10, 5'd7, 32'hDEADBEEF);

        // byte store into lane 3, then sub-word loads
        do_store(3'b000, 32'h13, 32'h00000080, 5'd1, 4'b1000, 32'h80000000);
        do_load(3'b000, 32'h13, 5'd2, 32'hFFFFFF80);
        do_load(3'b100, 32'h13, 5'd3, 32'h00000080);
        do_load(3'b001, 32'h12, 5'd4, 32'hFFFF80AD);
        do_load(3'b101, 32'h10, 5'd8, 32'h0000BEEF);

`ifndef MISALIGNED_SPLIT_EN
        do_err(1'b0, 3'b001, 32'h11, 32'h0, 2'b01);
        do_err(1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 2'b01);
`endif
        do_err(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 2'b10);
        do_err(1'b0, 3'b110, 32'h11, 32'h0, 2'b10);
        do_load(3'b010, 32'h10, 5'd9, 32'h80ADBEEF);

        // back-to-back stores keep ready high
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b010, 32'h20 + 32'(4 * i), 32'h100 + 32'(i), 5'(i));
            check("b2b_ready", 32'(req_ready), 32'd1);
            check("b2b_we", 32'(dmem_we), 32'd1);
            if (i > 0) check("b2b_rsp", 32'(rsp_valid), 32'd1);
            tick();
        end
        idle();
        check("b2b_rsp_last", 32'(rsp_valid), 32'd1);
        drive(1'b0, 3'b010, 32'h24, 32'h0, 5'd9);
        check("ldblk_ready_t", 32'(req_ready), 32'd1);
        tick();
        drive(1'b0, 3'b010, 32'h28, 32'h0, 5'd10);
        check("ldblk_ready_t1", 32'(req_ready), 32'd0);
        check("ldblk_data", rsp_data, 32'h101);
        tick();
        check("ldblk_ready_t2", 32'(req_ready), 32'd1);
        check("ldblk_raddr", dmem_raddr, 32'h28);
        tick(); idle();
        check("ldblk_data2", rsp_data, 32'h102);
        tick();

        // reset in the middle of a load aborts it
`ifdef MISALIGNED_SPLIT_EN
        rst_addr = 32'h26;
`else
        rst_addr = 32'h24;
`endif
        drive(1'b0, 3'b010, rst_addr, 32'h0, 5'd4);
        tick(); idle();
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        check("abort_dmem", 32'({dmem_re, dmem_we}), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        do_load(3'b010, 32'h24, 5'd6, 32'h101);

`ifdef MISALIGNED_SPLIT_EN
        drive(1'b1, 3'b010, 32'h0E, 32'h11223344, 5'd2);
        check("spl_st_waddr0", dmem_waddr, 32'h0C);
        check("spl_st_strb0", 32'(dmem_wstrb), 32'hC);
        check("spl_st_wdata0", dmem_wdata, 32'h33440000);
        tick(); idle();
        check("spl_st_waddr1", dmem_waddr, 32'h10);
        check("spl_st_strb1", 32'(dmem_wstrb), 32'h3);
        check("spl_st_wdata1", dmem_wdata, 32'h00001122);
        check("spl_st_ready", 32'(req_ready), 32'd0);
        check("spl_st_norsp", 32'(rsp_valid), 32'd0);
        tick();
        check("spl_st_rsp", 32'(rsp_valid), 32'd1);
        check("spl_st_err", 32'(rsp_err), 32'd0);
        drive(1'b0, 3'b010, 32'h0E, 32'h0, 5'd11);
        check("spl_ld_raddr0", dmem_raddr, 32'h0C);
        tick(); idle();
        check("spl_ld_raddr1", dmem_raddr, 32'h10);
        check("spl_ld_norsp", 32'(rsp_valid), 32'd0);
        tick();
        check("spl_ld_rsp", 32'(rsp_valid), 32'd1);
        check("spl_ld_data", rsp_data, 32'h11223344);
        check("spl_ld_rd", 32'(rsp_rd), 32'd11);
        tick();
        drive(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd12);
        check("wrap_raddr0", dmem_raddr, 32'hFFFFFFFC);
        tick(); idle();
        check("wrap_raddr1", dmem_raddr, 32'h0);
        tick();
        check("wrap_rsp", 32'(rsp_valid), 32'd1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
